// File: rtl/cd_global_xbar8x4.sv
// rtl/cd_global_xbar8x4.sv - 8x4 request / 4x8 reply combinational crossbar with per-output arbitration
// Optional round-robin arbitration: define CD_XBAR_RR_EN (default fixed priority, lowest index wins).
module cd_global_xbar8x4 #(
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          in_si,
    output logic [7:0]          in_ri,
    input  logic [8*DATA_W-1:0] in_di,
    output logic [3:0]          llc_so,
    input  logic [3:0]          llc_ro,
    output logic [4*DATA_W-1:0] llc_do,
    input  logic [3:0]          llc_si_r,
    output logic [3:0]          llc_ri_r,
    input  logic [4*DATA_W-1:0] llc_di_r,
    output logic [7:0]          out_so,
    input  logic [7:0]          out_ro,
    output logic [8*DATA_W-1:0] out_do
);
    localparam int NI = 8;
    localparam int NL = 4;

    function automatic logic [1:0] req_tgt(input logic [DATA_W-1:0] f);
        return {f[36], f[41]};
    endfunction

    function automatic logic [2:0] rep_tgt(input logic [DATA_W-1:0] f);
        return {f[36], f[41], f[32]};
    endfunction

    // Pointers hold the highest-priority index; tied to zero they give fixed priority.
    logic [2:0] req_ptr [NL];
    logic [1:0] rep_ptr [NI];
    logic [2:0] req_win [NL];
    logic [1:0] rep_win [NI];

    always_comb begin
        logic [2:0] idx;
        logic       hit;
        llc_so = '0;
        llc_do = '0;
        in_ri  = '0;
        for (int k = 0; k < NL; k++) begin
            req_win[k] = '0;
            hit        = 1'b0;
            // Walk priority order backwards so the last match is the highest priority one.
            for (int off = NI - 1; off >= 0; off--) begin
                idx = req_ptr[k] + 3'(off);
                if (in_si[idx] && req_tgt(in_di[idx*DATA_W +: DATA_W]) == 2'(k)) begin
                    req_win[k] = idx;
                    hit        = 1'b1;
                end
            end
            if (hit && llc_ro[k]) begin
                llc_so[k]                    = 1'b1;
                in_ri[req_win[k]]            = 1'b1;
                llc_do[k*DATA_W +: DATA_W]   = in_di[req_win[k]*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        logic [1:0] idx;
        logic       hit;
        out_so   = '0;
        out_do   = '0;
        llc_ri_r = '0;
        for (int o = 0; o < NI; o++) begin
            rep_win[o] = '0;
            hit        = 1'b0;
            for (int off = NL - 1; off >= 0; off--) begin
                idx = rep_ptr[o] + 2'(off);
                if (llc_si_r[idx] && rep_tgt(llc_di_r[idx*DATA_W +: DATA_W]) == 3'(o)) begin
                    rep_win[o] = idx;
                    hit        = 1'b1;
                end
            end
            if (hit && out_ro[o]) begin
                out_so[o]                  = 1'b1;
                llc_ri_r[rep_win[o]]       = 1'b1;
                out_do[o*DATA_W +: DATA_W] = llc_di_r[rep_win[o]*DATA_W +: DATA_W];
            end
        end
    end

`ifdef CD_XBAR_RR_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NL; k++) req_ptr[k] <= '0;
            for (int o = 0; o < NI; o++) rep_ptr[o] <= '0;
        end else begin
            for (int k = 0; k < NL; k++)
                if (llc_so[k]) req_ptr[k] <= req_win[k] + 3'd1;
            for (int o = 0; o < NI; o++)
                if (out_so[o]) rep_ptr[o] <= rep_win[o] + 2'd1;
        end
    end
`else
    logic unused_clk_reset;
    assign unused_clk_reset = clk ^ reset;

    always_comb begin
        for (int k = 0; k < NL; k++) req_ptr[k] = '0;
        for (int o = 0; o < NI; o++) rep_ptr[o] = '0;
    end
`endif

endmodule

// File: tb/tb_cd_global_xbar8x4.sv
// tb/tb_cd_global_xbar8x4.sv - directed and randomized checks of the crossbar against a reference model
module tb_cd_global_xbar8x4;
    localparam int W = 64;

    logic           clk = 1'b0;
    logic           reset;
    logic [7:0]     in_si, in_ri, out_so, out_ro;
    logic [8*W-1:0] in_di, out_do;
    logic [3:0]     llc_so, llc_ro, llc_si_r, llc_ri_r;
    logic [4*W-1:0] llc_do, llc_di_r;

    logic [W-1:0]   req_f [8];
    logic [W-1:0]   rep_f [4];

    logic [7:0]     e_in_ri, e_out_so;
    logic [3:0]     e_llc_so, e_llc_ri_r;
    logic [8*W-1:0] e_out_do;
    logic [4*W-1:0] e_llc_do;

    int tests = 0;
    int fails = 0;

    cd_global_xbar8x4 #(.DATA_W(W)) dut (
        .clk(clk), .reset(reset),
        .in_si(in_si), .in_ri(in_ri), .in_di(in_di),
        .llc_so(llc_so), .llc_ro(llc_ro), .llc_do(llc_do),
        .llc_si_r(llc_si_r), .llc_ri_r(llc_ri_r), .llc_di_r(llc_di_r),
        .out_so(out_so), .out_ro(out_ro), .out_do(out_do)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] mk(input logic [7:0] x, input logic [7:0] y, input logic [31:0] tag);
        return {16'h0, x, y, tag};
    endfunction

    // Reference: each output takes the lowest-index valid input aimed at it, if that output is ready.
    task automatic model();
        e_in_ri = '0; e_llc_so = '0; e_llc_do = '0;
        e_out_so = '0; e_llc_ri_r = '0; e_out_do = '0;
        for (int k = 0; k < 4; k++) begin
            int w = -1;
            for (int i = 0; i < 8; i++) begin
                int x = int'(req_f[i][47:40]);
                int y = int'(req_f[i][39:32]);
                int t = ((y / 16) % 2) * 2 + ((x / 2) % 2);
                if (w < 0 && in_si[i] && t == k) w = i;
            end
            if (w >= 0 && llc_ro[k]) begin
                e_llc_so[k] = 1'b1;
                e_in_ri[w] = 1'b1;
                e_llc_do[k*W +: W] = req_f[w];
            end
        end
        for (int o = 0; o < 8; o++) begin
            int w = -1;
            for (int r = 0; r < 4; r++) begin
                int x = int'(rep_f[r][47:40]);
                int y = int'(rep_f[r][39:32]);
                int t = ((y / 16) % 2) * 4 + ((x / 2) % 2) * 2 + (y % 2);
                if (w < 0 && llc_si_r[r] && t == o) w = r;
            end
            if (w >= 0 && out_ro[o]) begin
                e_out_so[o] = 1'b1;
                e_llc_ri_r[w] = 1'b1;
                e_out_do[o*W +: W] = rep_f[w];
            end
        end
    endtask

    task automatic apply();
        @(negedge clk);
        for (int i = 0; i < 8; i++) in_di[i*W +: W] = req_f[i];
        for (int r = 0; r < 4; r++) llc_di_r[r*W +: W] = rep_f[r];
        #1;
        model();
    endtask

    task automatic clear();
        in_si = '0; llc_ro = '0; llc_si_r = '0; out_ro = '0;
        for (int i = 0; i < 8; i++) req_f[i] = '0;
        for (int r = 0; r < 4; r++) rep_f[r] = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear();
        llc_ro = 4'hF; out_ro = 8'hFF;
        repeat (3) @(posedge clk);
        apply();
        tests++; if ({llc_so, in_ri, llc_ri_r, out_so} !== 24'h0) begin fails++;
            $display("FAIL reset_valids got %h exp 0", {llc_so, in_ri, llc_ri_r, out_so}); end
        tests++; if (llc_do !== '0 || out_do !== '0) begin fails++;
            $display("FAIL reset_data got %h / %h exp 0", llc_do, out_do); end
        in_si = 8'h01; req_f[0] = mk(8'h02, 8'h00, 32'h5A);
        apply();
        tests++; if (llc_so !== 4'b0010 || in_ri !== 8'h01) begin fails++;
            $display("FAIL reset_comb_path got %b/%b exp 0010/00000001", llc_so, in_ri); end
        reset = 1'b1;
        clear();
        apply();
        tests++; if ({llc_so, in_ri, llc_ri_r, out_so} !== 24'h0 || llc_do !== '0 || out_do !== '0) begin fails++;
            $display("FAIL idle_after_reset got %h exp 0", {llc_so, in_ri, llc_ri_r, out_so}); end
    endtask

    task automatic set_reply_distinct();
        llc_si_r = 4'b0011; out_ro = 8'hFF;
        rep_f[0] = mk(8'h00, 8'h00, 32'hA0);
        rep_f[1] = mk(8'h02, 8'h01, 32'hB1);
    endtask

    task automatic check_reply_distinct(input string nm);
        logic [8*W-1:0] ed;
        ed = '0; ed[0 +: W] = rep_f[0]; ed[3*W +: W] = rep_f[1];
        tests++; if (out_so !== 8'b00001001) begin fails++;
            $display("FAIL %s out_so got %b exp 00001001", nm, out_so); end
        tests++; if (out_do !== ed) begin fails++;
            $display("FAIL %s out_do got %h exp %h", nm, out_do, ed); end
        tests++; if (llc_ri_r !== 4'b0011) begin fails++;
            $display("FAIL %s llc_ri_r got %b exp 0011", nm, llc_ri_r); end
    endtask

    task automatic set_req_routing();
        in_si = 8'b10000001; llc_ro = 4'hF;
        req_f[0] = mk(8'h00, 8'h00, 32'h1111_0000);
        req_f[7] = mk(8'h02, 8'h10, 32'h7777_0007);
    endtask

    task automatic check_req_routing(input string nm);
        logic [4*W-1:0] ed;
        ed = '0; ed[0 +: W] = req_f[0]; ed[3*W +: W] = req_f[7];
        tests++; if (llc_so !== 4'b1001) begin fails++;
            $display("FAIL %s llc_so got %b exp 1001", nm, llc_so); end
        tests++; if (in_ri !== 8'b10000001) begin fails++;
            $display("FAIL %s in_ri got %b exp 10000001", nm, in_ri); end
        tests++; if (llc_do !== ed) begin fails++;
            $display("FAIL %s llc_do got %h exp %h", nm, llc_do, ed); end
    endtask

    task automatic test_reply_distinct();
        clear(); set_reply_distinct(); apply();
        check_reply_distinct("reply_distinct");
    endtask

    task automatic test_reply_conflict();
        logic [8*W-1:0] ed;
        clear();
        llc_si_r = 4'b0011; out_ro = 8'hFF;
        rep_f[0] = mk(8'h00, 8'h11, 32'hC0);
        rep_f[1] = mk(8'h00, 8'h11, 32'hC1);
        apply();
        ed = '0; ed[5*W +: W] = rep_f[0];
        tests++; if (out_so !== 8'b00100000) begin fails++;
            $display("FAIL reply_conflict out_so got %b exp 00100000", out_so); end
        tests++; if (out_do !== ed) begin fails++;
            $display("FAIL reply_conflict out_do got %h exp %h", out_do, ed); end
        tests++; if (llc_ri_r !== 4'b0001) begin fails++;
            $display("FAIL reply_conflict llc_ri_r got %b exp 0001", llc_ri_r); end
    endtask

    task automatic test_reply_blocked();
        clear();
        llc_si_r = 4'b0100; out_ro = 8'h7F;
        rep_f[2] = mk(8'h03, 8'h11, 32'hD2);
        apply();
        tests++; if (out_so !== 8'h00 || llc_ri_r !== 4'b0000) begin fails++;
            $display("FAIL reply_blocked got out_so=%b llc_ri_r=%b exp 0/0", out_so, llc_ri_r); end
        tests++; if (out_do[7*W +: W] !== '0) begin fails++;
            $display("FAIL reply_blocked o7 got %h exp 0", out_do[7*W +: W]); end
        out_ro = 8'hFF;
        apply();
        tests++; if (out_so !== 8'h80 || out_do[7*W +: W] !== rep_f[2]) begin fails++;
            $display("FAIL reply_unblocked got %b %h exp 10000000 %h", out_so, out_do[7*W +: W], rep_f[2]); end
    endtask

    task automatic test_req_routing();
        clear(); set_req_routing(); apply();
        check_req_routing("req_routing");
    endtask

    task automatic test_req_conflict();
        clear();
        in_si = 8'b00000110; llc_ro = 4'hF;
        req_f[1] = mk(8'h02, 8'h00, 32'hE1);
        req_f[2] = mk(8'h02, 8'h00, 32'hE2);
        apply();
        tests++; if (llc_so !== 4'b0010 || in_ri !== 8'b00000010) begin fails++;
            $display("FAIL req_conflict got %b/%b exp 0010/00000010", llc_so, in_ri); end
        tests++; if (llc_do[W +: W] !== req_f[1]) begin fails++;
            $display("FAIL req_conflict data got %h exp %h", llc_do[W +: W], req_f[1]); end
        llc_ro = 4'hD;
        apply();
        tests++; if (llc_so !== 4'b0000 || in_ri !== 8'h00 || llc_do !== '0) begin fails++;
            $display("FAIL req_not_ready got %b/%b exp 0000/00000000", llc_so, in_ri); end
        llc_ro = 4'hF; in_si = 8'b00000100;
        apply();
        tests++; if (in_ri !== 8'b00000100 || llc_do[W +: W] !== req_f[2]) begin fails++;
            $display("FAIL req_loser_later got %b %h exp 00000100 %h", in_ri, llc_do[W +: W], req_f[2]); end
    endtask

    task automatic test_concurrency();
        clear(); set_reply_distinct(); set_req_routing(); apply();
        check_reply_distinct("concurrent_reply");
        check_req_routing("concurrent_req");
    endtask

    task automatic test_random();
        int bad = 0;
        for (int n = 0; n < 400; n++) begin
            in_si = 8'($urandom); llc_si_r = 4'($urandom);
            llc_ro = 4'($urandom | $urandom); out_ro = 8'($urandom | $urandom);
            for (int i = 0; i < 8; i++) req_f[i] = {$urandom, $urandom};
            for (int r = 0; r < 4; r++) rep_f[r] = {$urandom, $urandom};
            apply();
            tests++; if (llc_so !== e_llc_so || in_ri !== e_in_ri) begin fails++; bad++;
                if (bad < 10) $display("FAIL rand_req_valid got %b/%b exp %b/%b", llc_so, in_ri, e_llc_so, e_in_ri); end
            tests++; if (llc_do !== e_llc_do) begin fails++; bad++;
                if (bad < 10) $display("FAIL rand_req_data got %h exp %h", llc_do, e_llc_do); end
            tests++; if (out_so !== e_out_so || llc_ri_r !== e_llc_ri_r) begin fails++; bad++;
                if (bad < 10) $display("FAIL rand_rep_valid got %b/%b exp %b/%b", out_so, llc_ri_r, e_out_so, e_llc_ri_r); end
            tests++; if (out_do !== e_out_do) begin fails++; bad++;
                if (bad < 10) $display("FAIL rand_rep_data got %h exp %h", out_do[255:0], e_out_do[255:0]); end
        end
    endtask

    initial begin
        test_reset();
        test_reply_distinct();
        test_reply_conflict();
        test_reply_blocked();
        test_req_routing();
        test_req_conflict();
        test_concurrency();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
